// File: rtl/picc_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : picc_tx_encoder
// Purpose  : ISO/IEC 14443-A PICC response transmitter, 106 kbit/s.
//            Frames response bytes with SOF, LSB-first data, odd parity and
//            EOF. Each bit is Manchester coded and gated by the 847 kHz
//            subcarrier to drive the load-modulation switch.
// Ports    : clk        fc/4 clock (sole clock)
//            rst_n      asynchronous active-low reset
//            in_data    response byte, sent LSB first
//            in_valid   in_data / in_last valid
//            in_last    byte is the final byte of the frame
//            out_ready  byte accepted this cycle when in_valid is high
//            out_mod    registered load-modulation drive
//            out_busy   frame in progress (SOF through EOF)
//            out_done   one-cycle pulse after EOF completes
//            out_err    pulse with out_done when the frame ended on underrun
// Revision : 1.0  initial release
// ============================================================================
module picc_tx_encoder #(
   parameter int BIT_CLKS  = 32,
   parameter int SUBC_CLKS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       out_ready,
   output logic       out_mod,
   output logic       out_busy,
   output logic       out_done,
   output logic       out_err
);

   localparam int c_PHASE_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
   localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(BIT_CLKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SOF    = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_EOF    = 3'd4
   } state_t;

   state_t                r_state,     w_state_n;
   logic [c_PHASE_W-1:0]  r_phase,     w_phase_n;
   logic [2:0]            r_bit_idx,   w_bit_idx_n;
   logic [7:0]            r_shift,     w_shift_n;
   logic                  r_par,       w_par_n;
   logic [7:0]            r_hold,      w_hold_n;
   logic                  r_hold_full, w_hold_full_n;
   logic                  r_hold_last, w_hold_last_n;
   logic                  r_last_seen, w_last_seen_n;
   logic                  r_err_flag,  w_err_flag_n;
   logic                  r_mod,       w_mod_n;
   logic                  r_done,      w_done_n;
   logic                  r_err,       w_err_n;

   logic w_accept;
   logic w_bit_end;
   logic w_send;
   logic w_bit;
   logic w_first_half;
   logic w_sc;

   assign out_ready = (r_state == ST_IDLE) ||
                      (((r_state == ST_DATA) || (r_state == ST_PARITY)) &&
                       !r_hold_full && !r_last_seen);
   assign w_accept  = in_valid && out_ready;
   assign w_bit_end = (r_phase == c_PHASE_LAST);

   assign out_mod  = r_mod;
   assign out_busy = (r_state != ST_IDLE);
   assign out_done = r_done;
   assign out_err  = r_err;

   // Next-state / datapath. The modulation output is derived from the
   // *next* state and phase so that the registered out_mod lines up with
   // the state register (first SOF sample visible the cycle after accept).
   always_comb begin
      w_state_n     = r_state;
      w_phase_n     = w_bit_end ? '0 : r_phase + 1'b1;
      w_bit_idx_n   = r_bit_idx;
      w_shift_n     = r_shift;
      w_par_n       = r_par;
      w_hold_n      = r_hold;
      w_hold_full_n = r_hold_full;
      w_hold_last_n = r_hold_last;
      w_last_seen_n = r_last_seen;
      w_err_flag_n  = r_err_flag;
      w_done_n      = 1'b0;
      w_err_n       = 1'b0;
      w_send        = 1'b0;
      w_bit         = 1'b0;
      w_first_half  = 1'b0;
      w_sc          = 1'b0;
      w_mod_n       = 1'b0;

      // Holding-register fill while the current byte is on the air.
      if (w_accept && ((r_state == ST_DATA) || (r_state == ST_PARITY))) begin
         w_hold_n      = in_data;
         w_hold_full_n = 1'b1;
         w_hold_last_n = in_last;
         w_last_seen_n = r_last_seen | in_last;
      end

      case (r_state)
         ST_IDLE: begin
            w_phase_n = '0;
            if (w_accept) begin
               w_shift_n     = in_data;
               w_par_n       = 1'b0;
               w_last_seen_n = in_last;
               w_err_flag_n  = 1'b0;
               w_hold_full_n = 1'b0;
               w_hold_last_n = 1'b0;
               w_bit_idx_n   = 3'd0;
               w_state_n     = ST_SOF;
            end
         end
         ST_SOF: begin
            if (w_bit_end) begin
               w_bit_idx_n = 3'd0;
               w_state_n   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_par_n   = r_par ^ r_shift[0];
               w_shift_n = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_n = ST_PARITY;
               end else begin
                  w_bit_idx_n = r_bit_idx + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               // w_hold_full_n already includes a byte accepted on this
               // final parity cycle, so a late-but-legal byte goes straight on.
               if (w_hold_full_n) begin
                  w_shift_n     = w_hold_n;
                  w_last_seen_n = w_last_seen_n | w_hold_last_n;
                  w_hold_full_n = 1'b0;
                  w_hold_last_n = 1'b0;
                  w_par_n       = 1'b0;
                  w_bit_idx_n   = 3'd0;
                  w_state_n     = ST_DATA;
               end else if (w_last_seen_n) begin
                  w_state_n = ST_EOF;
               end else begin
                  w_err_flag_n = 1'b1;
                  w_state_n    = ST_EOF;
               end
            end
         end
         ST_EOF: begin
            if (w_bit_end) begin
               w_done_n      = 1'b1;
               w_err_n       = r_err_flag;
               w_err_flag_n  = 1'b0;
               w_last_seen_n = 1'b0;
               w_hold_full_n = 1'b0;
               w_hold_last_n = 1'b0;
               w_state_n     = ST_IDLE;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase

      // Manchester coding of the bit that will be on the air next cycle.
      case (w_state_n)
         ST_SOF: begin
            w_send = 1'b1;
            w_bit  = 1'b1;
         end
         ST_DATA: begin
            w_send = 1'b1;
            w_bit  = w_shift_n[0];
         end
         ST_PARITY: begin
            w_send = 1'b1;
            w_bit  = ~w_par_n;
         end
         default: begin
            w_send = 1'b0;
            w_bit  = 1'b0;
         end
      endcase

      w_first_half = (32'(w_phase_n) < 32'(BIT_CLKS / 2));
      w_sc         = ((32'(w_phase_n) % 32'(SUBC_CLKS)) < 32'(SUBC_CLKS / 2));
      w_mod_n      = w_send && w_sc && (w_bit ? w_first_half : !w_first_half);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_bit_idx   <= 3'd0;
         r_shift     <= 8'd0;
         r_par       <= 1'b0;
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
         r_hold_last <= 1'b0;
         r_last_seen <= 1'b0;
         r_err_flag  <= 1'b0;
         r_mod       <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_phase     <= w_phase_n;
         r_bit_idx   <= w_bit_idx_n;
         r_shift     <= w_shift_n;
         r_par       <= w_par_n;
         r_hold      <= w_hold_n;
         r_hold_full <= w_hold_full_n;
         r_hold_last <= w_hold_last_n;
         r_last_seen <= w_last_seen_n;
         r_err_flag  <= w_err_flag_n;
         r_mod       <= w_mod_n;
         r_done      <= w_done_n;
         r_err       <= w_err_n;
      end
   end

endmodule
`default_nettype wire
